instr_fetch_seq: RTL and testbench

- Instruction fetch sequencer that drives the `instr` input of the instruction decoder.
- Reads opcode bytes from program memory over a req/ack interface and collects the trailing operand byte for two-byte opcodes (LDI = 13, JMP = 14).
- Presents each instruction to the datapath with a valid/ready handshake.
- Owns the program counter and performs the PC redirect for JMP (opcode 14) and RST (opcodes 15..31).

---
 rtl/instr_fetch_seq.sv | 130 +++++++++++++
 tb/tb_instr_fetch_seq.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: pulls opcode (+ optional operand) bytes from program
// memory, presents them to the decoder with valid/ready, and owns the PC.
module instr_fetch_seq #(
    parameter int ADDR_WIDTH   = 8,
    parameter int RESET_VECTOR = 0,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_rdata,
    output logic [7:0]            instr,
    output logic [7:0]            imm,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic                  illegal,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [CNT_WIDTH-1:0]  icount
);

    localparam logic [ADDR_WIDTH-1:0] RV     = ADDR_WIDTH'(RESET_VECTOR);
    localparam logic [7:0]            OP_NOP = 8'd12;
    localparam logic [7:0]            OP_LDI = 8'd13;
    localparam logic [7:0]            OP_JMP = 8'd14;
    localparam logic [7:0]            OP_RST = 8'd15;
    localparam logic [7:0]            OP_BAD = 8'd32;

    typedef enum logic [1:0] {IDLE, FETCH, OPERAND, ISSUE} state_t;

    state_t                state_reg;
    logic [7:0]            ir_reg;
    logic [7:0]            instr_reg;
    logic [7:0]            imm_reg;
    logic                  valid_reg;
    logic                  mem_req_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [CNT_WIDTH-1:0]  icount_reg;

    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  accept;

    assign pc_inc = pc_reg + ADDR_WIDTH'(1);
    assign accept = valid_reg && instr_ready;

    // PC to resume from once the current instruction retires; imm_reg holds the JMP target.
    always_comb begin
        pc_next = pc_reg;
        if (ir_reg == OP_JMP) begin
            pc_next = imm_reg[ADDR_WIDTH-1:0];
        end else if (ir_reg >= OP_RST && ir_reg < OP_BAD) begin
            pc_next = RV;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ir_reg       <= OP_NOP;
            instr_reg    <= OP_NOP;
            imm_reg      <= 8'd0;
            valid_reg    <= 1'b0;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= RV;
            pc_reg       <= RV;
            icount_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg    <= FETCH;
                    mem_req_reg  <= 1'b1;
                    mem_addr_reg <= pc_reg;
                end
                FETCH: begin
                    if (mem_ack) begin
                        ir_reg <= mem_rdata;
                        pc_reg <= pc_inc;
                        if (mem_rdata == OP_LDI || mem_rdata == OP_JMP) begin
                            state_reg    <= OPERAND;
                            mem_addr_reg <= pc_inc;
                        end else begin
                            state_reg   <= ISSUE;
                            mem_req_reg <= 1'b0;
                            valid_reg   <= 1'b1;
                            instr_reg   <= (mem_rdata >= OP_BAD) ? OP_NOP : mem_rdata;
                            imm_reg     <= 8'd0;
                        end
                    end
                end
                OPERAND: begin
                    if (mem_ack) begin
                        imm_reg     <= mem_rdata;
                        instr_reg   <= ir_reg;
                        pc_reg      <= pc_inc;
                        state_reg   <= ISSUE;
                        mem_req_reg <= 1'b0;
                        valid_reg   <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        valid_reg    <= 1'b0;
                        pc_reg       <= pc_next;
                        mem_req_reg  <= 1'b1;
                        mem_addr_reg <= pc_next;
                        state_reg    <= FETCH;
                        if (icount_reg != '1) begin
                            icount_reg <= icount_reg + CNT_WIDTH'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // The illegal flag marks the acceptance cycle itself, so it follows the handshake directly.
    assign illegal     = accept && (ir_reg >= OP_BAD);
    assign mem_req     = mem_req_reg;
    assign mem_addr    = mem_addr_reg;
    assign instr       = instr_reg;
    assign imm         = imm_reg;
    assign instr_valid = valid_reg;
    assign pc          = pc_reg;
    assign icount      = icount_reg;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Scoreboard bench for instr_fetch_seq: a program interpreter predicts the issue stream
// and fetch addresses; memory/ready responders are randomized.
`timescale 1ns/1ps
module tb_instr_fetch_seq;

    localparam int AW = 8;
    localparam int RV = 0;
    localparam int CW = 5;   // narrow counter so saturation is reachable quickly
    localparam logic [CW-1:0] CMAX = '1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [7:0]    mem_rdata = 8'd0;
    logic [7:0]    instr;
    logic [7:0]    imm;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic          illegal;
    logic [AW-1:0] pc;
    logic [CW-1:0] icount;

    always #5 clk = ~clk;

    instr_fetch_seq #(.ADDR_WIDTH(AW), .RESET_VECTOR(RV), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr(instr), .imm(imm), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .illegal(illegal), .pc(pc), .icount(icount)
    );

    typedef struct {
        logic [7:0]    instr;
        logic [7:0]    imm;
        logic          ill;
        logic [AW-1:0] pc;
        logic [CW-1:0] icnt;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] addr_q[$];
    logic [7:0]    mem [256];

    int n_cmp = 0;
    int n_fail = 0;
    int accepted = 0;
    int ready_mode = 0;
    int wait_max = 0;
    int fixed_wait = 0;
    int stall_left = 0;
    bit inject = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Program interpreter: walks memory from the reset vector, one entry per instruction.
    task automatic build(input int n);
        logic [AW-1:0] p;
        logic [7:0]    op;
        logic [7:0]    o;
        exp_t          e;
        p = AW'(RV);
        for (int i = 0; i < n; i++) begin
            op = mem[p];
            addr_q.push_back(p);
            p = p + AW'(1);
            if (op == 8'd13 || op == 8'd14) begin
                o = mem[p];
                addr_q.push_back(p);
                p = p + AW'(1);
            end else begin
                o = 8'd0;
            end
            e.instr = (op >= 8'd32) ? 8'd12 : op;
            e.imm   = o;
            e.ill   = (op >= 8'd32);
            e.pc    = p;
            e.icnt  = (i > int'(CMAX)) ? CMAX : CW'(i);
            exp_q.push_back(e);
            if (op == 8'd14) p = o[AW-1:0];
            else if (op >= 8'd15 && op <= 8'd31) p = AW'(RV);
        end
    endtask

    // Memory model: random or fixed wait states, checks address order and stability.
    initial begin : responder
        int            cnt;
        bit            busy;
        logic [AW-1:0] held;
        cnt = 0; busy = 1'b0; held = '0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (inject) begin
                mem_ack = 1'b1;
                mem_rdata = 8'h05;
                inject = 1'b0;
                busy = 1'b0;
            end else if (rst_n && mem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    held = mem_addr;
                    cnt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, wait_max));
                end else begin
                    check("mem_addr_stable", 32'(mem_addr), 32'(held));
                end
                if (cnt == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem[mem_addr];
                    busy = 1'b0;
                    if (addr_q.size() > 0) check("fetch_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
                end else begin
                    cnt--;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    initial begin : ready_driver
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: instr_ready = 1'b1;
                1: instr_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (instr_valid && stall_left > 0) begin
                        instr_ready = 1'b0;
                        stall_left--;
                    end else begin
                        instr_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    initial begin : monitor
        bit            hold;
        logic [7:0]    h_instr;
        logic [7:0]    h_imm;
        logic [AW-1:0] h_pc;
        logic [CW-1:0] h_cnt;
        exp_t          e;
        hold = 1'b0; h_instr = '0; h_imm = '0; h_pc = '0; h_cnt = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", 32'(instr_valid), 32'(1));
                    check("hold_instr", 32'(instr), 32'(h_instr));
                    check("hold_imm", 32'(imm), 32'(h_imm));
                    check("hold_pc", 32'(pc), 32'(h_pc));
                    check("hold_icount", 32'(icount), 32'(h_cnt));
                end
                if (instr_valid) check("mem_req_in_issue", 32'(mem_req), 32'(0));
                if (instr_valid && instr_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_issue: got instr 0x%0h with no expected entry at %0t", instr, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("instr", 32'(instr), 32'(e.instr));
                        check("imm", 32'(imm), 32'(e.imm));
                        check("illegal", 32'(illegal), 32'(e.ill));
                        check("pc_at_issue", 32'(pc), 32'(e.pc));
                        check("icount", 32'(icount), 32'(e.icnt));
                    end
                    accepted++;
                    hold = 1'b0;
                end else begin
                    check("illegal_quiet", 32'(illegal), 32'(0));
                    hold = instr_valid;
                    h_instr = instr; h_imm = imm; h_pc = pc; h_cnt = icount;
                end
            end
        end
    end

    task automatic fill_nop();
        for (int i = 0; i < 256; i++) mem[i] = 8'd12;
    endtask

    task automatic reset_dut();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'(0));
        check("rst_mem_addr", 32'(mem_addr), 32'(RV));
        check("rst_pc", 32'(pc), 32'(RV));
        check("rst_instr", 32'(instr), 32'(12));
        check("rst_imm", 32'(imm), 32'(0));
        check("rst_valid", 32'(instr_valid), 32'(0));
        check("rst_illegal", 32'(illegal), 32'(0));
        check("rst_icount", 32'(icount), 32'(0));
        exp_q.delete();
        addr_q.delete();
        accepted = 0;
    endtask

    task automatic release_dut(input int k, input int rmode, input int wmax, input int fwait);
        ready_mode = rmode;
        wait_max = wmax;
        fixed_wait = fwait;
        build(k + 10);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int k, input string name);
        int cyc;
        cyc = 0;
        while (accepted < k && cyc < k * 40 + 100) begin
            @(negedge clk);
            cyc++;
        end
        if (accepted < k) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout_%s: got %0d issues expected %0d", name, accepted, k);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w;
        fill_nop();
        reset_dut();

        // Single-byte first opcode: valid on the 2nd cycle after release.
        mem[0] = 8'd5;
        release_dut(3, 0, 0, 0);
        @(negedge clk);
        check("lat_c1_valid", 32'(instr_valid), 32'(0));
        check("lat_c1_req", 32'(mem_req), 32'(1));
        @(negedge clk);
        check("lat_c2_valid", 32'(instr_valid), 32'(1));
        wait_done(3, "single");

        // LDI with immediate.
        reset_dut(); fill_nop();
        mem[0] = 8'd13; mem[1] = 8'hA7;
        release_dut(3, 0, 0, 0);
        wait_done(3, "ldi");

        // JMP to 0x40.
        reset_dut(); fill_nop();
        mem[0] = 8'd14; mem[1] = 8'h40; mem[8'h40] = 8'd9;
        release_dut(3, 0, 0, 0);
        wait_done(3, "jmp");

        // Backpressure: five stalled ISSUE cycles.
        reset_dut(); fill_nop();
        mem[0] = 8'd3;
        stall_left = 5;
        release_dut(2, 2, 0, 0);
        wait_done(2, "stall");

        // Illegal opcode then RST back to the vector.
        reset_dut(); fill_nop();
        mem[0] = 8'h50; mem[1] = 8'd20;
        release_dut(5, 0, 0, 0);
        wait_done(5, "illegal_rst");

        // LDI at top of memory: operand wraps to address 0.
        reset_dut(); fill_nop();
        mem[0] = 8'd14; mem[1] = 8'hFF; mem[8'hFF] = 8'd13;
        release_dut(4, 0, 0, 0);
        wait_done(4, "wrap_ldi");

        // Long NOP run: pc wrap and icount saturation.
        reset_dut(); fill_nop();
        release_dut(300, 0, 0, 0);
        wait_done(300, "saturate");

        // Reset during a late operand fetch; stray ack after release must be ignored.
        reset_dut(); fill_nop();
        mem[0] = 8'd13; mem[1] = 8'h3C;
        release_dut(2, 0, 0, 3);
        w = 0;
        while (!(mem_req && mem_addr == AW'(1)) && w < 30) begin
            @(negedge clk);
            w++;
        end
        check("reach_operand", 32'(mem_addr), 32'(1));
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_req_drop", 32'(mem_req), 32'(0));
        exp_q.delete(); addr_q.delete(); accepted = 0;
        fixed_wait = 0;
        build(12);
        inject = 1'b1;
        @(posedge clk); #2;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("late_ack_pc", 32'(pc), 32'(RV));
        check("late_ack_addr", 32'(mem_addr), 32'(RV));
        wait_done(2, "late_ack");

        // Randomized program, wait states and backpressure.
        reset_dut();
        for (int i = 0; i < 256; i++) begin
            mem[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 255));
        end
        release_dut(200, 1, 3, -1);
        wait_done(200, "random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
